// File: rtl/picosoc_timer.sv
// picosoc_timer: programmable down-counting timer on the PicoSoC iomem bus.
//   The block is selected when iomem_addr[31:24] == ADDR_HI. Each access gets a
//   one-cycle iomem_ready pulse. The expiry period is (RELOAD+1)*(PRESCALE+1) cycles.
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   iomem_valid/ready    bus request and one-cycle acknowledge
//   iomem_wstrb          byte write strobes (0 = read)
//   iomem_addr           [31:24] selects the block, [4:2] selects the register
//   iomem_wdata/rdata    write data / pre-write register value (valid with ready)
//   irq                  registered level interrupt = STATUS.EXP & CTRL.IRQ_EN
// Register map: 0x00 CTRL{IRQ_EN,AUTO,EN}, 0x04 PRESCALE, 0x08 RELOAD,
//   0x0C COUNT (live read / load on write), 0x10 STATUS{EXP} (W1C),
//   0x14..0x1C read 0.
module picosoc_timer #(
  parameter logic [7:0] ADDR_HI    = 8'h04,
  parameter int         PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  // The run state is the CTRL.EN bit itself.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            en;
  logic                  auto_rl, irq_en, exp_flag;
  logic [PRESCALE_W-1:0] prescale, pcnt, prescale_new;
  logic [31:0]           reload, count, rd_val;
  logic                  sel, acc, wr, tick, expire;
  logic [2:0]            rsel;
  logic                  unused_addr;

  assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

  assign sel  = iomem_valid && (iomem_addr[31:24] == ADDR_HI);
  // A request that is still held after its ack must not be accepted a second time.
  assign acc  = sel && !iomem_ready;
  assign wr   = acc && (iomem_wstrb != 4'b0000);
  assign rsel = iomem_addr[4:2];

  assign tick   = (en == ST_RUN) && (pcnt == prescale);
  assign expire = tick && (count == 32'd0);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  always_comb begin
    prescale_new = prescale;
    for (int i = 0; i < PRESCALE_W; i++)
      if (iomem_wstrb[i/8]) prescale_new[i] = iomem_wdata[i];
  end

  always_comb begin
    rd_val = '0;
    case (rsel)
      3'd0: rd_val[2:0] = {irq_en, auto_rl, en};
      3'd1: rd_val[PRESCALE_W-1:0] = prescale;
      3'd2: rd_val = reload;
      3'd3: rd_val = count;
      3'd4: rd_val[0] = exp_flag;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      irq         <= 1'b0;
      en          <= ST_IDLE;
      auto_rl     <= 1'b0;
      irq_en      <= 1'b0;
      exp_flag    <= 1'b0;
      prescale    <= '0;
      pcnt        <= '0;
      reload      <= '0;
      count       <= '0;
    end else begin
      iomem_ready <= acc;
      if (acc) iomem_rdata <= rd_val;

      // Prescaler. A shrunken PRESCALE below pcnt simply wraps through 2^W.
      if (en == ST_IDLE || tick) pcnt <= '0;
      else                       pcnt <= pcnt + PRESCALE_W'(1);

      if (tick) begin
        if (count != 32'd0)  count <= count - 32'd1;
        else if (auto_rl)    count <= reload;
        else                 en    <= ST_IDLE;
      end

      // Expiry set beats a same-cycle W1C.
      exp_flag <= expire || (exp_flag &&
                  !(wr && rsel == 3'd4 && iomem_wstrb[0] && iomem_wdata[0]));

      // Bus writes come last so they override the counter/one-shot updates above.
      if (wr) begin
        case (rsel)
          3'd0: if (iomem_wstrb[0]) {irq_en, auto_rl, en} <= iomem_wdata[2:0];
          3'd1: prescale <= prescale_new;
          3'd2: reload   <= merge(reload, iomem_wdata, iomem_wstrb);
          3'd3: count    <= merge(count, iomem_wdata, iomem_wstrb);
          default: ;
        endcase
      end

      irq <= exp_flag && irq_en;
    end
  end

endmodule

// File: tb/tb_picosoc_timer.sv
// tb_picosoc_timer: directed self-checking bench for picosoc_timer.
//   Each task drives one scenario and compares against hand-derived values.
//   Cycle numbers in comments count posedges after the ack edge E0 of the
//   last setup write.
module tb_picosoc_timer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A_CTRL   = 32'h0400_0000;
  localparam logic [31:0] A_PRE    = 32'h0400_0004;
  localparam logic [31:0] A_RELOAD = 32'h0400_0008;
  localparam logic [31:0] A_COUNT  = 32'h0400_000C;
  localparam logic [31:0] A_STATUS = 32'h0400_0010;

  picosoc_timer dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // One bus transaction; returns #1 after the ack edge with valid dropped.
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] r);
    int n;
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!iomem_ready && n < 10);
    if (!iomem_ready) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%h no ack within 10 cycles", a);
    end
    r = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 4'hF, d, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    bus(a, 4'h0, 32'h0, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    while (!irq && n < max) begin @(posedge clk); #1; n++; end
  endtask

  task automatic do_reset();
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    // Reset asserted in the middle of a pending request: no ack may appear.
    resetn = 1'b0;
    iomem_valid = 1'b1; iomem_addr = A_RELOAD; iomem_wstrb = 4'h0;
    idle(2);
    checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", iomem_ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
    iomem_valid = 1'b0;
    resetn = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      rd(A_CTRL + 32'(i*4), r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h want=00000000", i, r); end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] r;
    int n;
    do_reset();
    wr(A_PRE, 32'd3);
    wr(A_COUNT, 32'd4);
    wr(A_CTRL, 32'h5);   // E0: ticks at E4,E8,..; COUNT 0 at E16, expire E20, irq E21
    wait_irq(40, n);
    checks++; if (n != 21) begin errors++; $display("FAIL oneshot_irq_delay got=%0d want=21", n); end
    rd(A_CTRL, r);
    checks++; if (r !== 32'h4) begin errors++; $display("FAIL oneshot_ctrl got=%h want=00000004", r); end
    rd(A_COUNT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL oneshot_count got=%h want=00000000", r); end
    rd(A_STATUS, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL oneshot_status got=%h want=00000001", r); end
    wr(A_CTRL, 32'h0);   // IRQ_EN off: irq drops one edge later
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_mask got=%b want=0", irq); end
  endtask

  task automatic test_autoreload();
    int n;
    do_reset();
    wr(A_PRE, 32'd0);
    wr(A_RELOAD, 32'd9);
    wr(A_COUNT, 32'd9);
    wr(A_CTRL, 32'h7);   // E0: decrement E1..E9, expire E10, irq E11
    wait_irq(40, n);
    checks++; if (n != 11) begin errors++; $display("FAIL auto_first_delay got=%0d want=11", n); end
    wr(A_STATUS, 32'h1); // clears at E12
    idle(1);             // E13: irq follows cleared EXP
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL auto_w1c_irq got=%b want=0", irq); end
    wait_irq(40, n);     // next expiry E20, irq E21 -> 8 more edges
    checks++; if (n != 8) begin errors++; $display("FAIL auto_period got=%0d want=8", n); end
  endtask

  task automatic test_collision();
    logic [31:0] r;
    do_reset();
    wr(A_PRE, 32'd3);
    wr(A_COUNT, 32'h200);
    wr(A_CTRL, 32'h1);   // E0; first tick edge E4
    idle(3);
    bus(A_COUNT, 4'hF, 32'h100, r);   // accepted on E4
    checks++; if (r !== 32'h200) begin errors++; $display("FAIL coll_prewrite got=%h want=00000200", r); end
    rd(A_COUNT, r);                   // sampled at E6, before the E8 tick
    checks++; if (r !== 32'h100) begin errors++; $display("FAIL coll_count got=%h want=00000100", r); end

    do_reset();
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h1);   // E0 (PRESCALE 0): 2->1 E1, 1->0 E2, expire E3
    idle(2);
    wr(A_STATUS, 32'h1); // W1C accepted on E3
    rd(A_STATUS, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL coll_w1c got=%h want=00000001", r); end
    rd(A_CTRL, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL coll_en_clear got=%h want=00000000", r); end
  endtask

  task automatic test_strobes();
    logic [31:0] r;
    do_reset();
    wr(A_RELOAD, 32'hAABBCCDD);
    bus(A_RELOAD, 4'b0010, 32'h0000_1100, r);
    checks++; if (r !== 32'hAABBCCDD) begin errors++; $display("FAIL strb_prewrite got=%h want=aabbccdd", r); end
    rd(A_RELOAD, r);
    checks++; if (r !== 32'hAABB11DD) begin errors++; $display("FAIL strb_reload got=%h want=aabb11dd", r); end
    wr(A_PRE, 32'hFFFF_FFFF);
    rd(A_PRE, r);
    checks++; if (r !== 32'h0000FFFF) begin errors++; $display("FAIL strb_prescale got=%h want=0000ffff", r); end
  endtask

  task automatic test_decode();
    logic [31:0] r, held;
    do_reset();
    wr(A_RELOAD, 32'h1234_5678);
    rd(A_RELOAD, held);
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL decode_noack cyc=%0d got=%b want=0", i, iomem_ready); end
    end
    checks++; if (iomem_rdata !== held) begin errors++; $display("FAIL decode_rdata_hold got=%h want=%h", iomem_rdata, held); end
    iomem_valid = 1'b0;
    idle(1);
    wr(32'h0400_0014, 32'hFFFF_FFFF);
    rd(32'h0400_0014, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL decode_unmapped14 got=%h want=00000000", r); end
    rd(32'h0400_0018, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL decode_unmapped18 got=%h want=00000000", r); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_collision();
    test_strobes();
    test_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
